// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- hazard / stall controller for a 5-stage in-order pipeline.
//
// Decides, every cycle, which pipeline latches advance and which load a
// bubble.  The stall sources, in decreasing priority, are:
//   1. halt reaching writeback
//   2. outstanding data-memory access
//   3. taken branch or jump
//   4. load-use hazard
//   5. instruction fetch miss
// Enables and flushes are combinational, derived from the state and the
// current inputs, so a hazard is handled in the cycle in which it appears.
//
// Ports
//   CLK, RST          clock, asynchronous active-high reset
//   ihit, dhit        instruction / data memory access complete this cycle
//   mem_req           EX/MEM latch holds a load or store
//   ex_dREN, ex_rd    ID/EX latch holds a load that writes ex_rd
//   id_rs, id_rt      source registers of the IF/ID instruction
//   br_taken          branch/jump resolved taken in EX
//   wb_halt           MEM/WB latch holds a halt
//   *_en              PC / latch advance enables
//   *_flush           load a bubble into the latch (only when its enable is 1)
//   halt              processor halted; sticky until reset
//   stall_cnt         saturating count of stalled (pc_en=0) cycles outside HALT
// -----------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_req,
    input  logic             ex_dREN,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             br_taken,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } stateT;

    stateT state;
    stateT nextState;

    logic loadUse;
    logic dataStall;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] val);
        if (&val) begin
            return val;
        end
        return val + 1'b1;
    endfunction

    // Register 0 is hard-wired to zero, so a load targeting it never creates
    // a real dependency.
    assign loadUse = ex_dREN && (ex_rd != 5'd0) &&
                     ((ex_rd == id_rs) || (ex_rd == id_rt));

    // In DWAIT the access is already known to be outstanding; only dhit
    // releases it.  In RUN a new access stalls only if it misses this cycle.
    assign dataStall = ((state == RUN)   && mem_req && !dhit) ||
                       ((state == DWAIT) && !dhit);

    // ---- combinational decode: enables, flushes, next state ----
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        nextState   = state;

        if (RST) begin
            // Hold everything and keep bubbles pending while in reset.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
            nextState   = RUN;
        end else if (state == HALT) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_en  = 1'b0;
            memwb_en  = 1'b0;
            nextState = HALT;
        end else if (wb_halt) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_en  = 1'b0;
            memwb_en  = 1'b0;
            nextState = HALT;
        end else if (dataStall) begin
            // Freeze the front of the pipe; let writeback drain with a bubble
            // so the in-flight memory instruction is not retired twice.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
            nextState   = DWAIT;
        end else begin
            nextState = RUN;
            if (br_taken) begin
                // Redirect fetch and squash the two wrong-path instructions.
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (loadUse) begin
                // Hold the dependent instruction in IF/ID one cycle.
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end else if (!ihit) begin
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
            end
        end
    end

    // ---- state, halt flag and stall counter ----
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= RUN;
            halt      <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state <= nextState;
            halt  <= (nextState == HALT);
            if (!pc_en && (state != HALT)) begin
                stall_cnt <= satInc(stall_cnt);
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl -- directed self-checking bench for pipe_ctrl.
// Two instances share all inputs: the default-width one is the main target,
// the CNT_W=4 one exercises counter saturation.
// Control outputs are grouped as
//   {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
//    ifid_flush, idex_flush, exmem_flush, memwb_flush}
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

    logic        CLK;
    logic        RST;
    logic        ihit, dhit, mem_req, ex_dREN, br_taken, wb_halt;
    logic [4:0]  ex_rd, id_rs, id_rt;

    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic        halt;
    logic [15:0] stall_cnt;

    logic        pcEnS, ifidEnS, idexEnS, exmemEnS, memwbEnS;
    logic        ifidFlushS, idexFlushS, exmemFlushS, memwbFlushS;
    logic        haltS;
    logic [3:0]  stallCntS;

    int checks;
    int passes;

    localparam logic [8:0] ALL_RUN  = 9'b11111_0000;
    localparam logic [8:0] IN_RST   = 9'b00000_1111;
    localparam logic [8:0] FROZEN   = 9'b00000_0000;
    localparam logic [8:0] LOAD_USE = 9'b00111_0100;
    localparam logic [8:0] IMISS    = 9'b01111_1000;
    localparam logic [8:0] BRANCH   = 9'b11111_1100;
    localparam logic [8:0] DSTALL   = 9'b00001_0001;

    pipe_ctrl dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
        .ex_dREN(ex_dREN), .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt),
        .br_taken(br_taken), .wb_halt(wb_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .halt(halt), .stall_cnt(stall_cnt)
    );

    pipe_ctrl #(.CNT_W(4)) dutSmall (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
        .ex_dREN(ex_dREN), .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt),
        .br_taken(br_taken), .wb_halt(wb_halt),
        .pc_en(pcEnS), .ifid_en(ifidEnS), .idex_en(idexEnS),
        .exmem_en(exmemEnS), .memwb_en(memwbEnS),
        .ifid_flush(ifidFlushS), .idex_flush(idexFlushS),
        .exmem_flush(exmemFlushS), .memwb_flush(memwbFlushS),
        .halt(haltS), .stall_cnt(stallCntS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [8:0] ctrl();
        return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, exmem_flush, memwb_flush};
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and registered outputs are read 1ns
    // after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Combinational outputs are sampled on the falling edge.
    task automatic checkCtrl(input string tag, input logic [8:0] exp);
        @(negedge CLK);
        checkVal(tag, {23'd0, ctrl()}, {23'd0, exp});
    endtask

    task automatic clearInputs();
        ihit = 1'b1; dhit = 1'b0; mem_req = 1'b0; ex_dREN = 1'b0;
        br_taken = 1'b0; wb_halt = 1'b0;
        ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    endtask

    task automatic resetPulse();
        RST = 1'b1;
        #2;
        checkVal("rst_ctrl", {23'd0, ctrl()}, {23'd0, IN_RST});
        checkVal("rst_halt", {31'd0, halt}, 32'd0);
        checkVal("rst_cnt", {16'd0, stall_cnt}, 32'd0);
        tick();
        RST = 1'b0;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        clearInputs();
        RST = 1'b1;
        #1;
        tick();
        resetPulse();

        // Clean run: everything advances, no stalls counted.
        for (int i = 0; i < 10; i++) begin
            checkCtrl("run_clean", ALL_RUN);
            tick();
        end
        checkVal("run_cnt", {16'd0, stall_cnt}, 32'd0);

        // Load-use through rt.
        ex_dREN = 1'b1; ex_rd = 5'd5; id_rt = 5'd5; id_rs = 5'd3;
        checkCtrl("lu_rt", LOAD_USE);
        tick();
        checkVal("lu_cnt1", {16'd0, stall_cnt}, 32'd1);

        // Load to r0 never stalls.
        ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        checkCtrl("lu_r0", ALL_RUN);
        tick();

        // Load-use through rs.
        ex_rd = 5'd7; id_rs = 5'd7; id_rt = 5'd2;
        checkCtrl("lu_rs", LOAD_USE);
        tick();
        clearInputs();
        checkVal("lu_cnt2", {16'd0, stall_cnt}, 32'd2);

        // Fetch miss.
        ihit = 1'b0;
        checkCtrl("imiss", IMISS);
        tick();
        checkVal("imiss_cnt", {16'd0, stall_cnt}, 32'd3);

        // Branch overrides fetch miss and load-use.
        br_taken = 1'b1; ex_dREN = 1'b1; ex_rd = 5'd5; id_rt = 5'd5;
        checkCtrl("br_over", BRANCH);
        tick();
        clearInputs();
        checkVal("br_cnt", {16'd0, stall_cnt}, 32'd3);

        resetPulse();

        // Data stall: three miss cycles (branch asserted in one, ignored),
        // released on the fourth.
        mem_req = 1'b1; dhit = 1'b0;
        checkCtrl("dstall0", DSTALL);
        tick();
        br_taken = 1'b1;
        checkCtrl("dstall1_br", DSTALL);
        tick();
        br_taken = 1'b0;
        checkCtrl("dstall2", DSTALL);
        tick();
        dhit = 1'b1;
        checkCtrl("dwait_rel", ALL_RUN);
        tick();
        clearInputs();
        checkVal("dstall_cnt", {16'd0, stall_cnt}, 32'd3);
        checkCtrl("back_run", ALL_RUN);
        tick();

        // Halt arriving while waiting on data memory.
        mem_req = 1'b1; dhit = 1'b0;
        checkCtrl("dstall_pre", DSTALL);
        tick();
        wb_halt = 1'b1;
        checkCtrl("halt_entry", FROZEN);
        tick();
        clearInputs();
        checkVal("halt_cnt", {16'd0, stall_cnt}, 32'd5);
        for (int i = 0; i < 20; i++) begin
            checkCtrl("halt_ctrl", FROZEN);
            checkVal("halt_flag", {31'd0, halt}, 32'd1);
            tick();
        end
        checkVal("halt_frozen_cnt", {16'd0, stall_cnt}, 32'd5);

        resetPulse();
        checkCtrl("post_rst_run", ALL_RUN);
        checkVal("post_rst_halt", {31'd0, halt}, 32'd0);

        // Saturation: 20 fetch-miss cycles.
        ihit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        clearInputs();
        checkVal("sat_small", {28'd0, stallCntS}, 32'd15);
        checkVal("sat_wide", {16'd0, stall_cnt}, 32'd20);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
